data_memory_arbiter_2m: RTL

//  Lets two Avalon-MM masters share one single-port 1024x32 data memory (altsyncram,

---
 rtl/data_memory_arbiter_2m_if.sv | 37 +++
 rtl/data_memory_arbiter_2m.sv | 126 ++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter_2m_if.sv
// Avalon-MM master/slave bundle shared by both requesters of the data memory arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface data_memory_arbiter_2m_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address,
    output byteenable,
    output read,
    output write,
    output writedata,
    input  waitrequest,
    input  readdata,
    input  readdatavalid
  );

  modport slave (
    input  address,
    input  byteenable,
    input  read,
    input  write,
    input  writedata,
    output waitrequest,
    output readdata,
    output readdatavalid
  );
endinterface

// File: rtl/data_memory_arbiter_2m.sv
// Two-master arbiter for a single-port data RAM with a 1-cycle read latency.
// Round-robin between A (CPU) and B (NoC DMA), with a bounded hold for back-to-back bursts.
module data_memory_arbiter_2m #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                reset_n,

  data_memory_arbiter_2m_if.slave a,
  data_memory_arbiter_2m_if.slave b,

  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);

  localparam logic MstA = 1'b0;
  localparam logic MstB = 1'b1;

  logic             last_grant_q, last_grant_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_owner_q, rd_owner_d;

  logic req_a, req_b;
  logic grant_a, grant_b;
  logic winner;
  logic accept;
  logic gnt_master;
  logic rd_accept;

  assign req_a = a.read | a.write;
  assign req_b = b.read | b.write;

  // A nonzero hold_cnt means last_grant_q was accepted in the previous cycle and still owns
  // the bus; zero means nobody owns it and the master that did not go last wins a tie.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    winner  = ~last_grant_q;
    if (reset_n) begin
      if (req_a && !req_b) begin
        grant_a = 1'b1;
      end else if (req_b && !req_a) begin
        grant_b = 1'b1;
      end else if (req_a && req_b) begin
        if (hold_cnt_q != '0 && hold_cnt_q < HoldMax) begin
          winner = last_grant_q;
        end else begin
          winner = ~last_grant_q;
        end
        grant_a = (winner == MstA);
        grant_b = (winner == MstB);
      end
    end
  end

  // A grant is only ever issued to a requester, so any grant is an accept.
  assign accept     = grant_a | grant_b;
  assign gnt_master = grant_b ? MstB : MstA;

  // Memory mux; a simultaneous read+write is treated as a write.
  always_comb begin
    mem_address    = a.address;
    mem_byteenable = a.byteenable;
    mem_writedata  = a.writedata;
    mem_write      = grant_a & a.write;
    if (grant_b) begin
      mem_address    = b.address;
      mem_byteenable = b.byteenable;
      mem_writedata  = b.writedata;
      mem_write      = b.write;
    end
  end

  assign mem_chipselect = accept;
  assign rd_accept      = accept & ~mem_write;

  always_comb begin
    last_grant_d = last_grant_q;
    hold_cnt_d   = '0;
    rd_pend_d    = rd_accept;
    rd_owner_d   = rd_owner_q;
    if (accept) begin
      last_grant_d = gnt_master;
      if (hold_cnt_q != '0 && last_grant_q == gnt_master) begin
        hold_cnt_d = (hold_cnt_q < HoldMax) ? hold_cnt_q + HoldW'(1) : hold_cnt_q;
      end else begin
        hold_cnt_d = HoldW'(1);
      end
    end
    if (rd_accept) begin
      rd_owner_d = gnt_master;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= MstB;
      hold_cnt_q   <= '0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= MstA;
    end else begin
      last_grant_q <= last_grant_d;
      hold_cnt_q   <= hold_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign a.waitrequest   = req_a & ~grant_a;
  assign b.waitrequest   = req_b & ~grant_b;
  assign a.readdatavalid = rd_pend_q & (rd_owner_q == MstA);
  assign b.readdatavalid = rd_pend_q & (rd_owner_q == MstB);
  assign a.readdata      = mem_readdata;
  assign b.readdata      = mem_readdata;

endmodule
